// File: rtl/branch_ctrl.sv
// ---------------------------------------------------------------------------
// branch_ctrl : IR holder, branch/jump/JAL decode, stall/flush sequencing, scan
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module branch_ctrl #(
   parameter logic [15:0] NOP = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] instr,
   input  logic [4:0]  flags_in,
   input  logic        flags_we,
   input  logic        mem_busy,
   input  logic        wb_valid,
   input  logic [3:0]  wb_reg,
   input  logic        scan_en,
   input  logic        scan_in,
   output logic        Br,
   output logic        Jmp,
   output logic        JAL,
   output logic [7:0]  disp,
   output logic [3:0]  rtarget_idx,
   output logic        stall,
   output logic        flush,
   output logic        scan_out
);

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_STALL = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [15:0] r_ir, w_ir_nxt;
   logic [4:0]  r_flags;
   logic [15:0] r_scan;

   logic       w_is_b, w_is_j, w_is_jal;
   logic       w_hazard, w_cond_true, w_active, w_taken;
   logic [3:0] w_cond;
   logic       w_c, w_l, w_f, w_z, w_n;

   assign w_is_b   = (r_ir[15:12] == 4'hC);
   assign w_is_j   = (r_ir[15:12] == 4'h4) && (r_ir[7:4] == 4'hC);
   assign w_is_jal = (r_ir[15:12] == 4'h4) && (r_ir[7:4] == 4'h8);
   assign w_cond   = r_ir[11:8];
   assign {w_c, w_l, w_f, w_z, w_n} = r_flags;

   always_comb begin
      w_cond_true = 1'b0;
      case (w_cond)
         4'h0:    w_cond_true = w_z;
         4'h1:    w_cond_true = ~w_z;
         4'h2:    w_cond_true = w_c;
         4'h3:    w_cond_true = ~w_c;
         4'h4:    w_cond_true = w_l;
         4'h5:    w_cond_true = ~w_l;
         4'h6:    w_cond_true = w_n;
         4'h7:    w_cond_true = ~w_n;
         4'h8:    w_cond_true = w_f;
         4'h9:    w_cond_true = ~w_f;
         4'hA:    w_cond_true = ~w_l & ~w_z;
         4'hB:    w_cond_true = w_l | w_z;
         4'hC:    w_cond_true = ~w_n & ~w_z;
         4'hD:    w_cond_true = w_n | w_z;
         4'hE:    w_cond_true = 1'b1;
         default: w_cond_true = 1'b0;
      endcase
   end

   assign w_hazard = (w_is_j | w_is_jal) & wb_valid & (wb_reg == r_ir[3:0]);
   assign stall    = mem_busy | w_hazard;

   // FLUSH gating keeps strobes quiet even if NOP is overridden with a branch word
   assign w_active = (r_state != S_FLUSH);
   assign Br       = w_active & w_is_b & w_cond_true & ~stall;
   assign Jmp      = w_active & w_is_j & w_cond_true & ~stall;
   assign JAL      = w_active & w_is_jal & ~stall;
   assign w_taken  = Br | Jmp | JAL;

   assign flush       = (r_state == S_FLUSH);
   assign disp        = r_ir[7:0];
   assign rtarget_idx = r_ir[3:0];
   assign scan_out    = r_scan[15];

   always_comb begin
      w_state_nxt = r_state;
      w_ir_nxt    = r_ir;
      case (r_state)
         S_FLUSH: begin
            w_state_nxt = S_RUN;
            w_ir_nxt    = instr;
         end
         default: begin
            if (stall) begin
               w_state_nxt = S_STALL;
            end else if (w_taken) begin
               w_state_nxt = S_FLUSH;
               w_ir_nxt    = NOP;
            end else begin
               w_state_nxt = S_RUN;
               w_ir_nxt    = instr;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_RUN;
         r_ir    <= NOP;
         r_flags <= 5'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ir    <= w_ir_nxt;
         if (flags_we) r_flags <= flags_in;
      end
   end

   // Scan register is intentionally free of reset so its contents survive for debug
   always_ff @(posedge clk) begin
      if (scan_en) r_scan <= r_ir;
      else         r_scan <= {r_scan[14:0], scan_in};
   end

endmodule

`default_nettype wire

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: decode table, directed sequences, random vs model.
`default_nettype none

module tb_branch_ctrl;

   logic        clk = 1'b0;
   logic        reset, flags_we, mem_busy, wb_valid, scan_en, scan_in;
   logic [15:0] instr;
   logic [4:0]  flags_in;
   logic [3:0]  wb_reg;
   logic        Br, Jmp, JAL, stall, flush, scan_out;
   logic [7:0]  disp;
   logic [3:0]  rtarget_idx;

   int n_checks = 0;
   int n_fail   = 0;

   branch_ctrl #(.NOP(16'h0000)) dut (
      .clk(clk), .reset(reset), .instr(instr), .flags_in(flags_in),
      .flags_we(flags_we), .mem_busy(mem_busy), .wb_valid(wb_valid),
      .wb_reg(wb_reg), .scan_en(scan_en), .scan_in(scan_in),
      .Br(Br), .Jmp(Jmp), .JAL(JAL), .disp(disp), .rtarget_idx(rtarget_idx),
      .stall(stall), .flush(flush), .scan_out(scan_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  flags;
      logic [15:0] ins;
      logic        mb;
      logic        wv;
      logic [3:0]  wr;
      logic        br;
      logic        jmp;
      logic        jal;
      logic        stl;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; flags_we = 1'b0; flags_in = 5'b0; mem_busy = 1'b0;
      wb_valid = 1'b0; wb_reg = 4'd0; scan_en = 1'b0; scan_in = 1'b0;
      instr = 16'h0000;
      tick();
      reset = 1'b0;
      #1;
   endtask

   // ---------------- reference model ----------------
   logic [15:0] m_ir;
   logic [4:0]  m_flags;
   bit          m_squash;
   logic [15:0] m_q, m_known;

   // 0 = no transfer, 1 = Bcond, 2 = Jcond, 3 = JAL
   function automatic int kind_of(input logic [15:0] w);
      if (w[15:12] == 4'hC) return 1;
      if (w[15:12] == 4'h4 && w[7:4] == 4'hC) return 2;
      if (w[15:12] == 4'h4 && w[7:4] == 4'h8) return 3;
      return 0;
   endfunction

   function automatic bit cond_ok(input logic [3:0] c, input logic [4:0] f);
      bit fc, fl, ff, fz, fn;
      {fc, fl, ff, fz, fn} = f;
      case (c)
         4'h0: return fz;          4'h1: return !fz;
         4'h2: return fc;          4'h3: return !fc;
         4'h4: return fl;          4'h5: return !fl;
         4'h6: return fn;          4'h7: return !fn;
         4'h8: return ff;          4'h9: return !ff;
         4'hA: return !fl && !fz;  4'hB: return fl || fz;
         4'hC: return !fn && !fz;  4'hD: return fn || fz;
         4'hE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [16:0] model_out();
      int k;
      bit haz, stl, go;
      k   = kind_of(m_ir);
      haz = (k >= 2) && wb_valid && (wb_reg == m_ir[3:0]);
      stl = mem_busy || haz;
      go  = !m_squash && !stl && (k == 3 || (k != 0 && cond_ok(m_ir[11:8], m_flags)));
      return {go && k == 1, go && k == 2, go && k == 3, stl, m_squash, m_ir[7:0], m_ir[3:0]};
   endfunction

   task automatic model_edge();
      logic [16:0] o;
      o = model_out();
      m_q     = scan_en ? m_ir : {m_q[14:0], scan_in};
      m_known = scan_en ? 16'hFFFF : {m_known[14:0], 1'b1};
      if (reset) begin
         m_ir = 16'h0000; m_flags = 5'b0; m_squash = 1'b0;
      end else begin
         if (flags_we) m_flags = flags_in;
         if (m_squash) begin
            m_ir = instr; m_squash = 1'b0;
         end else if (o[13]) begin
            // hold while stalled
         end else if (o[16] || o[15] || o[14]) begin
            m_ir = 16'h0000; m_squash = 1'b1;
         end else begin
            m_ir = instr;
         end
      end
   endtask

   function automatic logic [15:0] rand_instr();
      logic [3:0] c, r;
      logic [7:0] d;
      c = 4'($urandom_range(0, 15));
      r = 4'($urandom_range(0, 15));
      d = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 3))
         0: return {4'hC, c, d};
         1: return {4'h4, c, 4'hC, r};
         2: return {4'h4, c, 4'h8, r};
         default: return 16'($urandom);
      endcase
   endfunction

   logic [16:0] got, exp_o;
   logic [15:0] sc;

   initial begin
      // ---------------- decode table ----------------
      vq.push_back(vec_t'{5'b00010, 16'hC0FC, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0});
      vq.push_back(vec_t'{5'b00000, 16'hC0FC, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0});
      vq.push_back(vec_t'{5'b00000, 16'hC1FC, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0});
      vq.push_back(vec_t'{5'b10000, 16'hC200, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0});
      vq.push_back(vec_t'{5'b10000, 16'hC300, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0});
      vq.push_back(vec_t'{5'b00000, 16'hCA00, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0});
      vq.push_back(vec_t'{5'b01000, 16'hCA00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0});
      vq.push_back(vec_t'{5'b11111, 16'hCF00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0});
      vq.push_back(vec_t'{5'b00000, 16'h4EC3, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0});
      vq.push_back(vec_t'{5'b00000, 16'h4EC3, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1});
      vq.push_back(vec_t'{5'b00000, 16'h4EC3, 1'b0, 1'b1, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0});
      vq.push_back(vec_t'{5'b00000, 16'h4E85, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0});
      vq.push_back(vec_t'{5'b00000, 16'h4E85, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1});
      vq.push_back(vec_t'{5'b00000, 16'h4085, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0});
      vq.push_back(vec_t'{5'b00000, 16'h40C5, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0});
      vq.push_back(vec_t'{5'b00000, 16'hCE00, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1});
      vq.push_back(vec_t'{5'b00001, 16'hC600, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0});
      vq.push_back(vec_t'{5'b00000, 16'hCD00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0});
      vq.push_back(vec_t'{5'b00000, 16'h1234, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0});

      do_reset();
      mem_busy = 1'b1;
      #1;
      chk("reset_outputs", {Br, Jmp, JAL, flush, disp, rtarget_idx}, 32'h0);
      chk("reset_stall", stall, 1'b1);

      foreach (vq[i]) begin
         do_reset();
         flags_in = vq[i].flags; flags_we = 1'b1; instr = vq[i].ins;
         tick();
         flags_we = 1'b0; mem_busy = vq[i].mb; wb_valid = vq[i].wv; wb_reg = vq[i].wr;
         #1;
         chk($sformatf("table[%0d]", i),
             {Br, Jmp, JAL, stall, flush, disp, rtarget_idx},
             {vq[i].br, vq[i].jmp, vq[i].jal, vq[i].stl, 1'b0, vq[i].ins[7:0], vq[i].ins[3:0]});
      end

      // ---------------- BEQ taken ----------------
      do_reset();
      flags_in = 5'b00010; flags_we = 1'b1; tick();
      flags_we = 1'b0; instr = 16'hC0FC; tick();
      chk("beq_br", {Br, flush, disp}, {1'b1, 1'b0, 8'hFC});
      instr = 16'h1111; tick();
      chk("beq_flush", {Br, flush}, 2'b01);
      instr = 16'h2222; tick();
      chk("beq_target", {flush, disp}, {1'b0, 8'h22});

      // ---------------- BEQ not taken ----------------
      do_reset();
      instr = 16'hC0FC; tick();
      chk("bne_br", Br, 1'b0);
      instr = 16'h3333; tick();
      chk("bne_next", {flush, disp}, {1'b0, 8'h33});

      // ---------------- JAL with writeback hazard ----------------
      do_reset();
      instr = 16'h4E85; wb_valid = 1'b1; wb_reg = 4'd5; tick();
      chk("jal_haz1", {stall, JAL}, 2'b10);
      tick();
      chk("jal_haz2", {stall, JAL}, 2'b10);
      wb_valid = 1'b0; #1;
      chk("jal_go", {stall, JAL, rtarget_idx}, {1'b0, 1'b1, 4'd5});
      instr = 16'h0000; tick();
      chk("jal_flush", {flush, JAL}, 2'b10);

      // ---------------- JUC under mem_busy ----------------
      do_reset();
      instr = 16'h4EC3; tick();
      mem_busy = 1'b1; #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("juc_stall%0d", i), {stall, Jmp}, 2'b10);
         tick();
      end
      mem_busy = 1'b0; #1;
      chk("juc_go", {stall, Jmp, rtarget_idx}, {1'b0, 1'b1, 4'd3});

      // ---------------- reset during FLUSH ----------------
      do_reset();
      flags_in = 5'b00010; flags_we = 1'b1; tick();
      flags_we = 1'b0; instr = 16'hC0FC; tick();
      tick();
      chk("rst_in_flush_pre", flush, 1'b1);
      reset = 1'b1; tick();
      reset = 1'b0; #1;
      chk("rst_in_flush_post", {Br, Jmp, JAL, flush, disp, rtarget_idx}, 32'h0);

      // ---------------- scan chain ----------------
      do_reset();
      instr = 16'hC0FC; tick();
      scan_en = 1'b1; tick();
      scan_en = 1'b0; scan_in = 1'b0; #1;
      sc = 16'hC0FC;
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("scan_bit%0d", i), scan_out, sc[15 - i]);
         tick();
      end

      // ---------------- random vs model ----------------
      do_reset();
      m_ir = 16'h0000; m_flags = 5'b0; m_squash = 1'b0; m_q = 16'h0; m_known = 16'h0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         reset    = ($urandom_range(0, 39) == 0);
         instr    = rand_instr();
         flags_in = 5'($urandom_range(0, 31));
         flags_we = ($urandom_range(0, 3) == 0);
         mem_busy = ($urandom_range(0, 4) == 0);
         wb_valid = ($urandom_range(0, 1) == 0);
         wb_reg   = ($urandom_range(0, 1) == 0) ? m_ir[3:0] : 4'($urandom_range(0, 15));
         scan_en  = ($urandom_range(0, 9) == 0);
         scan_in  = 1'($urandom_range(0, 1));
         #1;
         got   = {Br, Jmp, JAL, stall, flush, disp, rtarget_idx};
         exp_o = model_out();
         chk($sformatf("rand%0d", cyc), got, exp_o);
         if (m_known[15]) chk($sformatf("rand_scan%0d", cyc), scan_out, m_q[15]);
         @(posedge clk);
         model_edge();
         #1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
